// File: rtl/dp_ram_pkg.sv
// Shared definitions for the dp_ram_pipe block.
//   state_e        : clear-sweep FSM encoding (ST_INIT sweeps zeros, ST_READY serves requests)
//   CM_READ_FIRST  : a same-address read/write returns the pre-write word
//   CM_WRITE_FIRST : a same-address read/write returns the freshly written bytes
package dp_ram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int CM_READ_FIRST  = 0;
  localparam int CM_WRITE_FIRST = 1;

endpackage

// File: rtl/dp_ram_pipe_if.sv
// Request/response bundle for dp_ram_pipe.
//   write_en/wr_addr/wr_be/data_in : write request
//   read_en/rd_addr                : read request
//   data_out/rd_valid/collision    : read response
//   init_busy                      : clear sweep running, requests are dropped
//   state_dbg                      : clear FSM state, for checkers
//
// Handshake: there is no ready/backpressure. A request is taken at every rising
// edge where its enable is high and init_busy is low; a request presented while
// init_busy is high is silently dropped. rd_valid is a one-cycle qualifier
// for data_out/collision and cannot be stalled by the consumer.
interface dp_ram_pipe_if #(
  parameter int RAM_WIDTH = 32,
  parameter int ADDR_SIZE = 4
);
  localparam int NUM_BYTES = RAM_WIDTH / 8;

  logic                   write_en;
  logic [ADDR_SIZE-1:0]   wr_addr;
  logic [NUM_BYTES-1:0]   wr_be;
  logic [RAM_WIDTH-1:0]   data_in;
  logic                   read_en;
  logic [ADDR_SIZE-1:0]   rd_addr;
  logic [RAM_WIDTH-1:0]   data_out;
  logic                   rd_valid;
  logic                   collision;
  logic                   init_busy;
  dp_ram_pkg::state_e     state_dbg;

  modport master (
    output write_en, wr_addr, wr_be, data_in, read_en, rd_addr,
    input  data_out, rd_valid, collision, init_busy, state_dbg
  );

  modport slave (
    input  write_en, wr_addr, wr_be, data_in, read_en, rd_addr,
    output data_out, rd_valid, collision, init_busy, state_dbg
  );

endinterface

// File: rtl/dp_ram_lane.sv
// One byte lane of the RAM: 8 bits x 2**ADDR_SIZE, one write port, one
// synchronous read port sharing a clock.
//   we/wr_addr/wr_data : byte write, takes effect at the rising edge
//   re/rd_addr         : read, rd_data updated at the rising edge, held otherwise
//   rd_data            : registered read data, cleared by rst_n (storage is not)
// WRITE_FIRST selects the same-address behaviour: 0 returns the old byte,
// 1 forwards wr_data when this lane is being written to the read address.
module dp_ram_lane #(
  parameter int ADDR_SIZE   = 4,
  parameter bit WRITE_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [7:0]           wr_data,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [7:0]           rd_data
);

  localparam int RAM_DEPTH = 2 ** ADDR_SIZE;

  logic [7:0] mem [RAM_DEPTH];

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (re) begin
      if (WRITE_FIRST && we && (wr_addr == rd_addr)) begin
        rd_data <= wr_data;
      end else begin
        rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: rtl/dp_ram_pipe.sv
// Parametrised simple dual-port RAM with byte enables, 1- or 2-cycle read
// latency, defined collision behaviour and an optional post-reset clear sweep.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : dp_ram_pipe_if slave (requests in, read response and status out)
// The top owns the clear FSM, the collision compare and the read valid
// pipeline; storage lives in RAM_WIDTH/8 dp_ram_lane instances.
module dp_ram_pipe
  import dp_ram_pkg::*;
#(
  parameter int RAM_WIDTH      = 32,
  parameter int ADDR_SIZE      = 4,
  parameter int RD_LATENCY     = 1,
  parameter int COLLISION_MODE = CM_READ_FIRST,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        reset,
  dp_ram_pipe_if.slave bus
);

  localparam int RAM_DEPTH = 2 ** ADDR_SIZE;
  localparam int NUM_BYTES = RAM_WIDTH / 8;
  localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(RAM_DEPTH - 1);

  if ((RAM_WIDTH % 8) != 0 || RAM_WIDTH < 8) begin : g_bad_width
    $error("dp_ram_pipe: RAM_WIDTH must be a positive multiple of 8");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("dp_ram_pipe: RD_LATENCY must be 1 or 2");
  end
  if ($bits(bus.data_in) != RAM_WIDTH || $bits(bus.wr_addr) != ADDR_SIZE) begin : g_bad_bus
    $error("dp_ram_pipe: interface parameters do not match the module");
  end

  // ---------------------------------------------------------------------------
  // Clear-sweep FSM
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RESET_STATE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_INIT: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == LAST_ADDR) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  logic ready;
  assign ready         = (state_q == ST_READY);
  assign bus.init_busy = ~ready;
  assign bus.state_dbg = state_q;

  // ---------------------------------------------------------------------------
  // Request qualification and lane write mux
  // ---------------------------------------------------------------------------
  logic                 rd_req, wr_req, hit;
  logic [ADDR_SIZE-1:0] lane_waddr;
  logic [RAM_WIDTH-1:0] lane_wdata;
  logic [NUM_BYTES-1:0] lane_we;
  logic [RAM_WIDTH-1:0] lane_rdata;

  assign rd_req = ready & bus.read_en;
  assign wr_req = ready & bus.write_en;
  // The collision flag ignores wr_be: a same-address write with no enabled
  // bytes still counts as a collision, it just changes nothing.
  assign hit    = rd_req & wr_req & (bus.rd_addr == bus.wr_addr);

  // During the sweep the lanes are owned by the FSM and write zeros.
  assign lane_waddr = ready ? bus.wr_addr : clr_addr_q;
  assign lane_wdata = ready ? bus.data_in : '0;
  assign lane_we    = ready ? (bus.wr_be & {NUM_BYTES{wr_req}}) : {NUM_BYTES{1'b1}};

  for (genvar k = 0; k < NUM_BYTES; k++) begin : g_lane
    dp_ram_lane #(
      .ADDR_SIZE   (ADDR_SIZE),
      .WRITE_FIRST (COLLISION_MODE == CM_WRITE_FIRST)
    ) u_lane (
      .clk     (clk),
      .rst_n   (reset),
      .we      (lane_we[k]),
      .wr_addr (lane_waddr),
      .wr_data (lane_wdata[8*k +: 8]),
      .re      (rd_req),
      .rd_addr (bus.rd_addr),
      .rd_data (lane_rdata[8*k +: 8])
    );
  end

  // ---------------------------------------------------------------------------
  // Read valid pipeline: stage 1 aligns with the lane read registers.
  // ---------------------------------------------------------------------------
  logic valid1_q, coll1_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid1_q <= 1'b0;
      coll1_q  <= 1'b0;
    end else begin
      valid1_q <= rd_req;
      coll1_q  <= hit;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic                 valid2_q, coll2_q;
    logic [RAM_WIDTH-1:0] data2_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        valid2_q <= 1'b0;
        coll2_q  <= 1'b0;
        data2_q  <= '0;
      end else begin
        valid2_q <= valid1_q;
        coll2_q  <= coll1_q;
        if (valid1_q) begin
          data2_q <= lane_rdata;
        end
      end
    end

    assign bus.data_out  = data2_q;
    assign bus.rd_valid  = valid2_q;
    assign bus.collision = coll2_q;
  end else begin : g_lat1
    // Lane read registers only load on a read, so data_out holds otherwise.
    assign bus.data_out  = lane_rdata;
    assign bus.rd_valid  = valid1_q;
    assign bus.collision = coll1_q;
  end

endmodule
